gelato_ifetch: RTL and testbench

//  Instruction fetch stage. Takes one warp PC at a time from the fetch scheduler and reads
//  the instruction word from the instruction memory port. Hands the instruction to the

---
 rtl/gelato_ifetch.sv | 130 +++++++++++++
 tb/tb_gelato_ifetch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_ifetch.sv
// Instruction fetch stage: one warp PC in flight, single-beat instruction read,
// tagged hand-off to the decoder with misaligned-PC and timeout error codes.
module gelato_ifetch #(
    parameter int PC_W    = 32,
    parameter int INST_W  = 32,
    parameter int WARP_W  = 5,
    parameter int SPLIT_W = 4,
    parameter int TMO_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               skd_valid,
    input  logic [PC_W-1:0]    skd_pc,
    input  logic [WARP_W-1:0]  skd_warp,
    input  logic [SPLIT_W-1:0] skd_split,
    output logic               skd_caught,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [PC_W-1:0]    mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic [INST_W-1:0]  mem_resp_data,
    input  logic               flush_valid,
    input  logic [WARP_W-1:0]  flush_warp,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INST_W-1:0]  dec_inst,
    output logic [PC_W-1:0]    dec_pc,
    output logic [WARP_W-1:0]  dec_warp,
    output logic [SPLIT_W-1:0] dec_split,
    output logic [1:0]         dec_err
);

    // state     | meaning
    // IDLE      | waiting for a scheduler offer
    // REQ       | read request presented, waiting for mem_req_ready
    // WAIT_RESP | request accepted, waiting for data or timeout
    // OUT       | instruction presented to the decoder
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, OUT} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t             state;
    logic [7:0]         cnt;
    logic               kill;
    logic [PC_W-1:0]    pc_q;
    logic [WARP_W-1:0]  warp_q;
    logic [SPLIT_W-1:0] split_q;
    logic               flush_hit;

    assign flush_hit    = flush_valid && (flush_warp == warp_q);
    assign mem_req_addr = pc_q;
    assign dec_pc       = pc_q;
    assign dec_warp     = warp_q;
    assign dec_split    = split_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            skd_caught    <= 1'b0;
            mem_req_valid <= 1'b0;
            dec_valid     <= 1'b0;
            dec_err       <= 2'd0;
            dec_inst      <= '0;
            cnt           <= 8'd0;
            kill          <= 1'b0;
            pc_q          <= '0;
            warp_q        <= '0;
            split_q       <= '0;
        end else if (rdy) begin
            skd_caught <= 1'b0;
            case (state)
                IDLE: begin
                    if (skd_valid) begin
                        skd_caught <= 1'b1;
                        pc_q       <= skd_pc;
                        warp_q     <= skd_warp;
                        split_q    <= skd_split;
                        kill       <= 1'b0;
                        if (skd_pc[1:0] != 2'b00) begin
                            state     <= OUT;
                            dec_valid <= 1'b1;
                            dec_err   <= 2'd1;
                            dec_inst  <= '0;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // once accepted the read cannot be recalled, so a flush then only marks it dead
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= 8'd0;
                        kill          <= flush_hit;
                        state         <= WAIT_RESP;
                    end else if (flush_hit) begin
                        mem_req_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid || cnt == TMO_LAST) begin
                        kill <= 1'b0;
                        if (kill || flush_hit) begin
                            state <= IDLE;
                        end else begin
                            state     <= OUT;
                            dec_valid <= 1'b1;
                            dec_err   <= mem_resp_valid ? 2'd0 : 2'd2;
                            dec_inst  <= mem_resp_valid ? mem_resp_data : '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (flush_hit) kill <= 1'b1;
                    end
                end
                OUT: begin
                    if (dec_ready || flush_hit) begin
                        dec_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gelato_ifetch.sv
// Self-checking bench for gelato_ifetch: directed scenarios plus randomized
// fetches compared against a transaction-level latency/result model.
module tb_gelato_ifetch;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        skd_valid;
    logic [31:0] skd_pc;
    logic [4:0]  skd_warp;
    logic [3:0]  skd_split;
    logic        skd_caught;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        flush_valid;
    logic [4:0]  flush_warp;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_inst, dec_pc;
    logic [4:0]  dec_warp;
    logic [3:0]  dec_split;
    logic [1:0]  dec_err;

    int checks = 0;
    int failures = 0;

    int          o_caught, o_req_cycles, o_req_hs, o_dec_w;
    bit          o_dec_seen, o_addr_ok, o_stable, o_timeout, o_dec_after;
    logic [31:0] o_inst, o_pc;
    logic [1:0]  o_err;
    logic [4:0]  o_warp;
    logic [3:0]  o_split;

    gelato_ifetch #(.PC_W(32), .INST_W(32), .WARP_W(5), .SPLIT_W(4), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .skd_valid(skd_valid), .skd_pc(skd_pc), .skd_warp(skd_warp), .skd_split(skd_split),
        .skd_caught(skd_caught),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .flush_valid(flush_valid), .flush_warp(flush_warp),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
        .dec_pc(dec_pc), .dec_warp(dec_warp), .dec_split(dec_split), .dec_err(dec_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: what one fetch should look like, from the fetch rules alone.
    // dec_w = wait cycles (counted from the request handshake) until dec_valid shows.
    task automatic model_fetch(input logic [31:0] pc, input int req_lat, input int resp_at,
                               input logic [31:0] data, output int e_req_cycles,
                               output int e_dec_w, output logic [1:0] e_err,
                               output logic [31:0] e_inst);
        if (pc[1:0] != 2'b00) begin
            e_req_cycles = 0; e_dec_w = 0; e_err = 2'd1; e_inst = 32'h0;
        end else if (resp_at >= 1 && resp_at <= TMO) begin
            e_req_cycles = req_lat + 1; e_dec_w = resp_at + 1; e_err = 2'd0; e_inst = data;
        end else begin
            e_req_cycles = req_lat + 1; e_dec_w = TMO + 1; e_err = 2'd2; e_inst = 32'h0;
        end
    endtask

    // Memory/decoder agent for one fetch; records what it observed in o_* variables.
    task automatic drive_fetch(input logic [31:0] pc, input logic [4:0] warp,
                               input logic [3:0] split, input int req_lat, input int resp_at,
                               input int dec_lat, input logic [31:0] data);
        bit hs_pend, hs_done, dec_hs;
        int wcyc, dec_cyc;
        hs_pend = 0; hs_done = 0; dec_hs = 0; wcyc = 0; dec_cyc = 0;
        o_caught = 0; o_req_cycles = 0; o_req_hs = 0; o_dec_w = -1;
        o_dec_seen = 0; o_addr_ok = 1; o_stable = 1;
        o_inst = 'x; o_pc = 'x; o_err = 'x; o_warp = 'x; o_split = 'x;
        skd_pc = pc; skd_warp = warp; skd_split = split; skd_valid = 1'b1;
        tick;
        skd_valid = 1'b0; skd_pc = $urandom; skd_warp = 5'($urandom); skd_split = 4'($urandom);
        for (int t = 0; t < 1000 && !dec_hs; t++) begin
            o_caught += int'(skd_caught);
            if (hs_pend) begin hs_done = 1; hs_pend = 0; end
            if (hs_done) wcyc++;
            mem_resp_valid = hs_done && (wcyc == resp_at);
            mem_resp_data  = mem_resp_valid ? data : $urandom;
            if (mem_req_valid) begin
                if (mem_req_addr !== pc) o_addr_ok = 0;
                o_req_cycles++;
                mem_req_ready = (o_req_cycles > req_lat);
                if (mem_req_ready) begin hs_pend = 1; o_req_hs++; end
            end else begin
                mem_req_ready = 1'($urandom_range(0, 1));
            end
            if (dec_valid) begin
                if (!o_dec_seen) begin
                    o_dec_seen = 1; o_dec_w = wcyc; o_inst = dec_inst; o_pc = dec_pc;
                    o_err = dec_err; o_warp = dec_warp; o_split = dec_split;
                end else if ({dec_inst, dec_pc, dec_err, dec_warp, dec_split} !==
                             {o_inst, o_pc, o_err, o_warp, o_split}) begin
                    o_stable = 0;
                end
                dec_ready = (dec_cyc >= dec_lat);
                dec_cyc++;
                if (dec_ready) dec_hs = 1;
            end else begin
                dec_ready = 1'b0;
            end
            tick;
        end
        o_timeout = !dec_hs;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; dec_ready = 1'b0;
        o_caught += int'(skd_caught);
        o_dec_after = dec_valid;
    endtask

    task automatic start_fetch(input logic [31:0] pc, input logic [4:0] warp);
        skd_pc = pc; skd_warp = warp; skd_split = 4'd1; skd_valid = 1'b1;
        tick;
        skd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; skd_valid = 1'b1; skd_pc = 32'h40; mem_resp_valid = 1'b1;
        tick; tick;
        skd_valid = 1'b0; mem_resp_valid = 1'b0;
        checks++; if (skd_caught !== 1'b0) begin failures++; $display("FAIL reset_caught got=%b exp=0", skd_caught); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req_valid); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%b exp=0", dec_valid); end
        checks++; if ({dec_err, dec_inst, mem_req_addr} !== 66'h0) begin failures++; $display("FAIL reset_payload err=%0d inst=%h addr=%h exp=0", dec_err, dec_inst, mem_req_addr); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        drive_fetch(32'h100, 5'd3, 4'd2, 0, 2, 0, 32'hDEADBEEF);
        checks++; if (o_caught !== 1) begin failures++; $display("FAIL basic_caught_pulses got=%0d exp=1", o_caught); end
        checks++; if (o_timeout !== 1'b0 || o_dec_seen !== 1'b1) begin failures++; $display("FAIL basic_dec_seen got=%b exp=1", o_dec_seen); end
        checks++; if (o_inst !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_inst got=%h exp=deadbeef", o_inst); end
        checks++; if (o_warp !== 5'd3 || o_pc !== 32'h100 || o_split !== 4'd2) begin failures++; $display("FAIL basic_tags got=%0d/%h/%0d exp=3/100/2", o_warp, o_pc, o_split); end
        checks++; if (o_err !== 2'd0) begin failures++; $display("FAIL basic_err got=%0d exp=0", o_err); end
        checks++; if (o_dec_w !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", o_dec_w); end
        checks++; if (o_dec_after !== 1'b0) begin failures++; $display("FAIL basic_dec_drop got=%b exp=0", o_dec_after); end
    endtask

    task automatic test_misaligned;
        drive_fetch(32'h102, 5'd3, 4'd0, 0, 1, 0, 32'h1111_2222);
        checks++; if (o_caught !== 1) begin failures++; $display("FAIL mis_caught got=%0d exp=1", o_caught); end
        checks++; if (o_req_cycles !== 0) begin failures++; $display("FAIL mis_no_req got=%0d exp=0", o_req_cycles); end
        checks++; if (o_err !== 2'd1 || o_inst !== 32'h0) begin failures++; $display("FAIL mis_err got=%0d/%h exp=1/0", o_err, o_inst); end
        checks++; if (o_dec_w !== 0) begin failures++; $display("FAIL mis_latency got=%0d exp=0", o_dec_w); end
    endtask

    task automatic test_req_stall;
        drive_fetch(32'h100, 5'd3, 4'd0, 5, 1, 0, 32'hCAFE_F00D);
        checks++; if (o_addr_ok !== 1'b1) begin failures++; $display("FAIL stall_addr_stable got=%b exp=1", o_addr_ok); end
        checks++; if (o_req_cycles !== 6 || o_req_hs !== 1) begin failures++; $display("FAIL stall_req got=%0d cyc/%0d hs exp=6/1", o_req_cycles, o_req_hs); end
        checks++; if (o_inst !== 32'hCAFE_F00D) begin failures++; $display("FAIL stall_inst got=%h exp=cafef00d", o_inst); end
    endtask

    task automatic test_timeout;
        drive_fetch(32'h180, 5'd4, 4'd0, 0, -1, 0, 32'h5555_AAAA);
        checks++; if (o_dec_w !== TMO + 1 || o_err !== 2'd2 || o_inst !== 32'h0) begin failures++; $display("FAIL tmo_none got=w%0d e%0d i%h exp=w%0d e2 i0", o_dec_w, o_err, o_inst, TMO + 1); end
        drive_fetch(32'h184, 5'd4, 4'd0, 1, TMO, 0, 32'h7777_1234);
        checks++; if (o_dec_w !== TMO + 1 || o_err !== 2'd0 || o_inst !== 32'h7777_1234) begin failures++; $display("FAIL tmo_resp_wins got=w%0d e%0d i%h exp=w%0d e0 i77771234", o_dec_w, o_err, o_inst, TMO + 1); end
        drive_fetch(32'h188, 5'd4, 4'd0, 0, TMO + 1, 0, 32'h7777_9999);
        checks++; if (o_dec_w !== TMO + 1 || o_err !== 2'd2) begin failures++; $display("FAIL tmo_resp_late got=w%0d e%0d exp=w%0d e2", o_dec_w, o_err, TMO + 1); end
    endtask

    task automatic test_flush;
        int n;
        // kill in WAIT_RESP, response discarded
        start_fetch(32'h200, 5'd3);
        mem_req_ready = 1'b1; tick; mem_req_ready = 1'b0;
        flush_valid = 1'b1; flush_warp = 5'd3; tick; flush_valid = 1'b0;
        tick;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0; tick; mem_resp_valid = 1'b0;
        n = 0;
        repeat (6) begin n += int'(dec_valid); tick; end
        checks++; if (n !== 0) begin failures++; $display("FAIL flush_wait_no_dec got=%0d exp=0", n); end
        drive_fetch(32'h204, 5'd3, 4'd5, 0, 1, 0, 32'h0BAD_CAFE);
        checks++; if (o_caught !== 1 || o_inst !== 32'h0BAD_CAFE || o_err !== 2'd0) begin failures++; $display("FAIL flush_next_offer got=c%0d i%h e%0d exp=c1 i0badcafe e0", o_caught, o_inst, o_err); end
        // kill in REQ: request withdrawn
        start_fetch(32'h300, 5'd3);
        flush_valid = 1'b1; flush_warp = 5'd3; tick; flush_valid = 1'b0;
        n = 0;
        repeat (5) begin n += int'(mem_req_valid) + int'(dec_valid); mem_req_ready = 1'b1; tick; end
        mem_req_ready = 1'b0;
        checks++; if (n !== 0) begin failures++; $display("FAIL flush_req_withdraw got=%0d exp=0", n); end
        // kill in OUT
        start_fetch(32'h310, 5'd3);
        mem_req_ready = 1'b1; tick; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h3131_3131; tick; mem_resp_valid = 1'b0;
        n = int'(dec_valid);
        flush_valid = 1'b1; flush_warp = 5'd3; tick; flush_valid = 1'b0;
        n += 2 * int'(dec_valid);
        tick;
        n += 2 * int'(dec_valid);
        checks++; if (n !== 1) begin failures++; $display("FAIL flush_out_drop got=%0d exp=1", n); end
        // flush of another warp has no effect
        start_fetch(32'h320, 5'd3);
        mem_req_ready = 1'b1; tick; mem_req_ready = 1'b0;
        flush_valid = 1'b1; flush_warp = 5'd4; tick; flush_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h3232_3232; tick; mem_resp_valid = 1'b0;
        checks++; if (dec_valid !== 1'b1 || dec_inst !== 32'h3232_3232) begin failures++; $display("FAIL flush_other_warp got=v%b i%h exp=v1 i32323232", dec_valid, dec_inst); end
        dec_ready = 1'b1; tick; dec_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int last, pulses, bad_gap, decs;
        last = -1; pulses = 0; bad_gap = 0; decs = 0;
        mem_req_ready = 1'b1; dec_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
        skd_pc = 32'h400; skd_warp = 5'd1; skd_split = 4'd0; skd_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            tick;
            if (skd_caught) begin
                if (last >= 0 && t - last != 4) bad_gap++;
                last = t; pulses++;
            end
            if (dec_valid && dec_inst === 32'h1234_5678) decs++;
        end
        skd_valid = 1'b0;
        tick;
        mem_req_ready = 1'b0; dec_ready = 1'b0; mem_resp_valid = 1'b0;
        checks++; if (pulses !== 10 || bad_gap !== 0) begin failures++; $display("FAIL b2b_caught got=%0d pulses %0d bad gaps exp=10/0", pulses, bad_gap); end
        checks++; if (decs !== 10) begin failures++; $display("FAIL b2b_dec got=%0d exp=10", decs); end
    endtask

    task automatic test_rdy_rst;
        bit stable;
        int n;
        start_fetch(32'h500, 5'd5);
        mem_req_ready = 1'b1; tick; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h5050_5050; tick; mem_resp_valid = 1'b0;
        stable = dec_valid;
        repeat (10) begin
            tick;
            if (!dec_valid || dec_inst !== 32'h5050_5050 || dec_pc !== 32'h500 || dec_warp !== 5'd5) stable = 0;
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL hold_payload got=%b exp=1", stable); end
        rdy = 1'b0; dec_ready = 1'b1;
        repeat (3) tick;
        checks++; if (dec_valid !== 1'b1 || dec_inst !== 32'h5050_5050) begin failures++; $display("FAIL rdy_freeze got=v%b i%h exp=v1 i50505050", dec_valid, dec_inst); end
        rdy = 1'b1; tick; dec_ready = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rdy_resume_hs got=%b exp=0", dec_valid); end
        // reset mid WAIT_RESP; a response during rdy=0 is not seen
        start_fetch(32'h600, 5'd6);
        mem_req_ready = 1'b1; tick; mem_req_ready = 1'b0;
        rdy = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h6666_6666;
        tick; tick;
        mem_resp_valid = 1'b0; rdy = 1'b1;
        tick;
        checks++; if (dec_valid !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL rdy_resp_ignored got=v%b r%b exp=0/0", dec_valid, mem_req_valid); end
        rst = 1'b1; tick; rst = 1'b0;
        checks++; if ({skd_caught, mem_req_valid, dec_valid, dec_err, dec_inst, mem_req_addr} !== 69'h0) begin failures++; $display("FAIL rst_mid_outputs got=c%b r%b v%b e%0d i%h a%h exp=0", skd_caught, mem_req_valid, dec_valid, dec_err, dec_inst, mem_req_addr); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h7E7E_7E7E; tick; mem_resp_valid = 1'b0;
        n = 0;
        repeat (TMO + 5) begin n += int'(dec_valid) + int'(mem_req_valid); tick; end
        checks++; if (n !== 0) begin failures++; $display("FAIL rst_late_resp got=%0d exp=0", n); end
        drive_fetch(32'h604, 5'd6, 4'd3, 0, 2, 1, 32'h6060_6060);
        checks++; if (o_caught !== 1 || o_inst !== 32'h6060_6060 || o_err !== 2'd0) begin failures++; $display("FAIL rst_recover got=c%0d i%h e%0d exp=c1 i60606060 e0", o_caught, o_inst, o_err); end
    endtask

    task automatic test_random;
        logic [31:0] pc, data, e_inst;
        logic [4:0]  warp;
        logic [3:0]  split;
        logic [1:0]  e_err;
        int req_lat, resp_at, dec_lat, e_req, e_w;
        for (int i = 0; i < 40; i++) begin
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            warp = 5'($urandom); split = 4'($urandom); data = $urandom;
            req_lat = $urandom_range(0, 4); dec_lat = $urandom_range(0, 4);
            resp_at = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(1, 3) : $urandom_range(1, 6);
            model_fetch(pc, req_lat, resp_at, data, e_req, e_w, e_err, e_inst);
            drive_fetch(pc, warp, split, req_lat, resp_at, dec_lat, data);
            checks++; if (o_caught !== 1 || o_timeout !== 1'b0) begin failures++; $display("FAIL rnd%0d_handshake got=c%0d to%b exp=c1 to0", i, o_caught, o_timeout); end
            checks++; if (o_req_cycles !== e_req || o_req_hs !== (e_req == 0 ? 0 : 1)) begin failures++; $display("FAIL rnd%0d_req got=%0d/%0d exp=%0d", i, o_req_cycles, o_req_hs, e_req); end
            checks++; if (o_dec_w !== e_w) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, o_dec_w, e_w); end
            checks++; if (o_err !== e_err || o_inst !== e_inst) begin failures++; $display("FAIL rnd%0d_result got=e%0d i%h exp=e%0d i%h", i, o_err, o_inst, e_err, e_inst); end
            checks++; if (o_pc !== pc || o_warp !== warp || o_split !== split) begin failures++; $display("FAIL rnd%0d_tags got=%h/%0d/%0d exp=%h/%0d/%0d", i, o_pc, o_warp, o_split, pc, warp, split); end
            checks++; if (o_stable !== 1'b1 || o_addr_ok !== 1'b1 || o_dec_after !== 1'b0) begin failures++; $display("FAIL rnd%0d_stability got=s%b a%b d%b exp=1/1/0", i, o_stable, o_addr_ok, o_dec_after); end
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        skd_valid = 1'b0; skd_pc = '0; skd_warp = '0; skd_split = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        flush_valid = 1'b0; flush_warp = '0; dec_ready = 1'b0;
        test_reset();
        test_basic();
        test_misaligned();
        test_req_stall();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_rdy_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
